ramsey_scan_scheduler: RTL

Sequences the POP cycle generator through an automatic free-precession scan, so Ramsey fringes can be taken without pressing the freeprecess buttons by hand. On `start` it captures a start delay, step, point count and cycles-per-point. It then issues one `cycle_req` per POP cycle and holds a stable `freeprecess` value for the current point. It advances the value after the configured number of `cycle_done` acknowledgements. It sits between the mode/button logic in the top level and POPtimers, in the 2.5 MHz domain.

---
 rtl/ramsey_scan_scheduler.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ramsey_scan_scheduler.sv
// ---------------------------------------------------------------------------
// ramsey_scan_scheduler
//
// Drives the POP cycle generator through an automatic free-precession scan
// so Ramsey fringes can be recorded without pressing the freeprecess
// buttons by hand. A scan runs n_points points. Each point issues
// cycles_per_point POP cycle requests. Between points, freeprecess steps
// by fp_step and saturates at all-ones.
//
// Ports (all logic in the clk_2M5 domain):
//   clk_2M5          2.5 MHz clock, posedge
//   reset_n          asynchronous active-low reset
//   start            begin a scan (sampled in IDLE only)
//   abort            terminate a running scan, no done/point_strobe
//   fp_start         first free-precession delay
//   fp_step          delay increment per point
//   n_points         number of scan points
//   cycles_per_point POP cycles averaged per point
//   cycle_done       end-of-POP-cycle pulse from POPtimers
//   cycle_req        pulse: run one POP cycle with current freeprecess
//   freeprecess      delay for the current point
//   point_index      0-based index of the current point
//   point_strobe     pulse when a point completes
//   busy             high while a scan is running
//   done             pulse on normal completion (or on a zero-length start)
//   saturated        sticky per scan: freeprecess addition carried out
//   timeout          pulse on watchdog expiry
//
// Optional feature: define SCAN_WATCHDOG_EN to add a TIMEOUT_W-bit
// watchdog on the WAIT state. Without it, WAIT waits indefinitely and
// timeout stays 0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ramsey_scan_scheduler #(
  parameter int WIDTH     = 16,
  parameter int PTS_W     = 8,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT_W = 20
) (
  input  logic             clk_2M5,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] fp_start,
  input  logic [WIDTH-1:0] fp_step,
  input  logic [PTS_W-1:0] n_points,
  input  logic [CNT_W-1:0] cycles_per_point,
  input  logic             cycle_done,
  output logic             cycle_req,
  output logic [WIDTH-1:0] freeprecess,
  output logic [PTS_W-1:0] point_index,
  output logic             point_strobe,
  output logic             busy,
  output logic             done,
  output logic             saturated,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [PTS_W-1:0] npts_q, npts_d;
  logic [CNT_W-1:0] cpp_q, cpp_d;
  logic [CNT_W-1:0] cycle_cnt, cnt_d, cnt_inc;
  logic [WIDTH-1:0] fp_d;
  logic [PTS_W-1:0] idx_d;
  logic             req_d, strobe_d, busy_d, done_d, sat_d;
  logic [WIDTH:0]   fp_sum;

`ifdef SCAN_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_cnt, wd_d;
  logic                 timeout_d;
`endif

  // Next-state and next-output logic. Every output is a register, so the
  // pulses (cycle_req, point_strobe, done, timeout) are decided here one
  // clock ahead and appear in the clock after the deciding edge.
  always_comb begin
    state_d  = state;
    step_d   = step_q;
    npts_d   = npts_q;
    cpp_d    = cpp_q;
    cnt_d    = cycle_cnt;
    fp_d     = freeprecess;
    idx_d    = point_index;
    busy_d   = busy;
    sat_d    = saturated;
    req_d    = 1'b0;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    cnt_inc  = cycle_cnt + CNT_W'(1);
    // One extra bit catches the carry that triggers clamping.
    fp_sum   = {1'b0, freeprecess} + {1'b0, step_q};
`ifdef SCAN_WATCHDOG_EN
    wd_d      = wd_cnt;
    timeout_d = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          if ((n_points != '0) && (cycles_per_point != '0)) begin
            step_d  = fp_step;
            npts_d  = n_points;
            cpp_d   = cycles_per_point;
            fp_d    = fp_start;
            idx_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            busy_d  = 1'b1;
            req_d   = 1'b1;
            state_d = ISSUE;
          end else begin
            // A zero-length scan completes immediately without running.
            done_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
`ifdef SCAN_WATCHDOG_EN
          wd_d = '0;
`endif
        end
      end

      WAIT: begin
        // Abort wins over a simultaneous cycle_done.
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cycle_done) begin
          if (cnt_inc < cpp_q) begin
            cnt_d   = cnt_inc;
            req_d   = 1'b1;
            state_d = ISSUE;
          end else begin
            strobe_d = 1'b1;
            cnt_d    = '0;
            if (point_index == npts_q - PTS_W'(1)) begin
              // Final point: freeprecess and point_index keep their values.
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              idx_d   = point_index + PTS_W'(1);
              req_d   = 1'b1;
              state_d = ISSUE;
              if (fp_sum[WIDTH]) begin
                fp_d  = '1;
                sat_d = 1'b1;
              end else begin
                fp_d = fp_sum[WIDTH-1:0];
              end
            end
          end
        end else begin
`ifdef SCAN_WATCHDOG_EN
          if (wd_cnt == '1) begin
            timeout_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            wd_d = wd_cnt + TIMEOUT_W'(1);
          end
`endif
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, captured configuration and registered outputs.
  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      step_q       <= '0;
      npts_q       <= '0;
      cpp_q        <= '0;
      cycle_cnt    <= '0;
      freeprecess  <= '0;
      point_index  <= '0;
      cycle_req    <= 1'b0;
      point_strobe <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      saturated    <= 1'b0;
    end else begin
      state        <= state_d;
      step_q       <= step_d;
      npts_q       <= npts_d;
      cpp_q        <= cpp_d;
      cycle_cnt    <= cnt_d;
      freeprecess  <= fp_d;
      point_index  <= idx_d;
      cycle_req    <= req_d;
      point_strobe <= strobe_d;
      busy         <= busy_d;
      done         <= done_d;
      saturated    <= sat_d;
    end
  end

`ifdef SCAN_WATCHDOG_EN
  // Watchdog counter and its expiry pulse.
  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      wd_cnt  <= wd_d;
      timeout <= timeout_d;
    end
  end
`else
  // No watchdog: timeout is a constant 0, built from a TIMEOUT_W-wide zero
  // so the parameter stays referenced in this build.
  assign timeout = |TIMEOUT_W'(0);
`endif

endmodule
